move_executor: RTL and testbench
================================

MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 SHALL have parameter ORD_REG, default 4'd0, meaning the register index holding the board word.
REQ-002 SHALL have parameter CNT_REG, default 4'd1, meaning the register index holding the move counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  move request present.
REQ-006 SHALL have port req_dir  input  2  blank-movement direction: 00 up, 01 down, 10 left, 11 right.
REQ-007 SHALL have port req_ready  output  1  executor can accept a request.
REQ-008 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-009 SHALL have port resp_legal  output  1  move was applied; valid with resp_valid.
REQ-010 SHALL have port resp_solved  output  1  resulting board equals SOLVED; valid with resp_valid.
REQ-011 SHALL have port src0  output  4  register-file read address 0, tied to ORD_REG.
REQ-012 SHALL have port src1  output  4  register-file read address 1, tied to CNT_REG.
REQ-013 SHALL have port data0  input  40  combinational read data for src0.
REQ-014 SHALL have port data1  input  40  combinational read data for src1.
REQ-015 SHALL have port we  output  1  register-file write enable.
REQ-016 SHALL have port dst  output  4  register-file write address.
REQ-017 SHALL have port data  output  40  register-file write data.

Function
REQ-018 Board word SHALL be bits [17:0], six 3-bit tiles; position p (0..5) at bits [17-3p:15-3p]; positions 0-2 top row, 3-5 bottom row, left to right; tile 0 is blank.
REQ-019 FSM states SHALL be IDLE, LOAD, EVAL, WR_ORD, WR_CNT, RESP; one state per cycle except IDLE.
REQ-020 req_ready SHALL be 1 only in IDLE; handshake is req_valid && req_ready, capturing req_dir, next state LOAD.
REQ-021 LOAD SHALL register data0 (board) and data1 (counter); later register-file changes do not affect the move.
REQ-022 EVAL SHALL locate the blank (lowest-indexed tile 0 if several) and compute target: up p-3, down p+3, left p-1, right p+1.
REQ-023 Move SHALL be illegal when no blank exists, up from row 0, down from row 1, left from column 0, or right from column 2; illegal goes EVAL -> RESP with no writes.
REQ-024 Legal move SHALL swap the tiles at blank and target, preserving bits [39:18].
REQ-025 WR_ORD SHALL drive we=1, dst=ORD_REG, data=new board; WR_CNT SHALL drive we=1, dst=CNT_REG, data=counter+1 modulo 2^40.
REQ-026 we SHALL be 0 outside WR_ORD and WR_CNT; dst and data SHALL be 0 when we=0.
REQ-027 RESP SHALL assert resp_valid for exactly one cycle with resp_legal and resp_solved, then return to IDLE.
REQ-028 resp_solved SHALL compare bits [17:0] of the new board (or the unchanged board if illegal) with SOLVED.
REQ-029 Latency SHALL be: handshake in cycle 0, resp_valid in cycle 5 for legal moves and cycle 3 for illegal moves.
REQ-030 Requests while req_ready=0 SHALL be ignored, not queued.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, clear captured registers, and set req_ready=1, resp_valid=0, resp_legal=0, resp_solved=0, we=0, dst=0, data=0.
REQ-032 Reset mid-operation SHALL abandon the move; no further writes are issued after rst_n deasserts.

Structure
REQ-033 Package puzzle_pkg SHALL hold the direction encoding, TILE_W=3, NUM_POS=6, and SOLVED=18'h0A728.
REQ-034 Blank location, legality check and swap SHALL be one combinational sub-module, puzzle_move_calc.

Verification
REQ-035 Board 18'h0A728, counter 0, dir left -> cycle 3 write dst 0 data 0x0A705; cycle 4 write dst 1 data 1; cycle 5 resp_legal=1, resp_solved=0.
REQ-036 Board 18'h0A728, dir down -> no write, resp_valid in cycle 3 with resp_legal=0 and resp_solved=1.
REQ-037 Board 18'h0A728, dir up -> write 0x0A12B; then board 0x0A12B, dir down -> write 0x0A728 with resp_solved=1.
REQ-038 Counter 40'hFF_FFFF_FFFF, any legal move -> counter written as 0.
REQ-039 Board with no blank (18'h0A729) -> resp_legal=0, no writes.
REQ-040 Assert rst_n in WR_ORD -> outputs return to reset values immediately and the counter is never written.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared definitions for the sliding-tile puzzle: direction encoding,
// board geometry and the solved board pattern.
package puzzle_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int TILE_W  = 3;
    localparam int NUM_POS = 6;
    localparam int BOARD_W = TILE_W * NUM_POS;

    localparam logic [BOARD_W-1:0] SOLVED = 18'h0A728;

    // Position 0 occupies the most significant tile slot of the board word.
    function automatic int pos_lsb(input logic [2:0] p);
        return TILE_W * (NUM_POS - 1 - int'(p));
    endfunction

endpackage

// File: rtl/puzzle_move_calc.sv
// Combinational move evaluation: finds the blank, checks that the requested
// blank movement stays on the 2x3 board, and produces the swapped board.
module puzzle_move_calc
    import puzzle_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  dir,
    output logic        legal,
    output logic [17:0] new_board
);

    logic       found;
    logic [2:0] blank_pos;
    logic       has_target;
    logic [2:0] target;

    // Locate the lowest-indexed blank, derive the target and swap the two tiles.
    always_comb begin
        found     = 1'b0;
        blank_pos = '0;
        for (int unsigned i = 0; i < NUM_POS; i++) begin
            if (!found && board[pos_lsb(3'(i)) +: TILE_W] == '0) begin
                found     = 1'b1;
                blank_pos = 3'(i);
            end
        end

        has_target = 1'b0;
        target     = '0;
        case (dir)
            DIR_UP: begin
                has_target = (blank_pos >= 3'd3);
                target     = blank_pos - 3'd3;
            end
            DIR_DOWN: begin
                has_target = (blank_pos < 3'd3);
                target     = blank_pos + 3'd3;
            end
            DIR_LEFT: begin
                has_target = !(blank_pos == 3'd0 || blank_pos == 3'd3);
                target     = blank_pos - 3'd1;
            end
            DIR_RIGHT: begin
                has_target = !(blank_pos == 3'd2 || blank_pos == 3'd5);
                target     = blank_pos + 3'd1;
            end
            default: begin
                has_target = 1'b0;
                target     = '0;
            end
        endcase

        legal     = found && has_target;
        new_board = board;
        if (legal) begin
            new_board[pos_lsb(blank_pos) +: TILE_W] = board[pos_lsb(target) +: TILE_W];
            new_board[pos_lsb(target) +: TILE_W]    = '0;
        end
    end

endmodule

// File: rtl/move_executor.sv
// Executes one blank-tile move per request: reads the board and move counter
// from the register file, writes back the updated board and counter+1 when
// the move is legal, then reports legality and solved status.
module move_executor
    import puzzle_pkg::*;
#(
    parameter logic [3:0] ORD_REG = 4'd0,
    parameter logic [3:0] CNT_REG = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_dir,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_legal,
    output logic        resp_solved,
    output logic [3:0]  src0,
    output logic [3:0]  src1,
    input  logic [39:0] data0,
    input  logic [39:0] data1,
    output logic        we,
    output logic [3:0]  dst,
    output logic [39:0] data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_WR_ORD = 3'd3;
    localparam logic [2:0] S_WR_CNT = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]  state;
    logic [1:0]  dir_q;
    logic [39:0] board_q;
    logic [39:0] cnt_q;
    logic [17:0] new_board_q;
    logic        legal_q;
    logic        solved_q;

    logic        calc_legal;
    logic [17:0] calc_board;

    assign src0 = ORD_REG;
    assign src1 = CNT_REG;

    puzzle_move_calc u_calc (
        .board     (board_q[17:0]),
        .dir       (dir_q),
        .legal     (calc_legal),
        .new_board (calc_board)
    );

    // Sequencing: capture request, snapshot operands, evaluate, write back, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dir_q       <= '0;
            board_q     <= '0;
            cnt_q       <= '0;
            new_board_q <= '0;
            legal_q     <= 1'b0;
            solved_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        dir_q <= req_dir;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    board_q <= data0;
                    cnt_q   <= data1;
                    state   <= S_EVAL;
                end
                S_EVAL: begin
                    new_board_q <= calc_board;
                    legal_q     <= calc_legal;
                    solved_q    <= (calc_board == SOLVED);
                    state       <= calc_legal ? S_WR_ORD : S_RESP;
                end
                S_WR_ORD: state <= S_WR_CNT;
                S_WR_CNT: state <= S_RESP;
                S_RESP:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    always_comb begin
        req_ready   = (state == S_IDLE);
        resp_valid  = (state == S_RESP);
        resp_legal  = (state == S_RESP) && legal_q;
        resp_solved = (state == S_RESP) && solved_q;
        we          = 1'b0;
        dst         = '0;
        data        = '0;
        case (state)
            S_WR_ORD: begin
                we   = 1'b1;
                dst  = ORD_REG;
                data = {board_q[39:18], new_board_q};
            end
            S_WR_CNT: begin
                we   = 1'b1;
                dst  = CNT_REG;
                data = cnt_q + 40'd1;
            end
            default: begin
                we   = 1'b0;
                dst  = '0;
                data = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_move_executor.sv
// Bench for move_executor: register-file model, tile-array move model,
// per-cycle output checker, directed cases and randomized requests.
module tb_move_executor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_dir = 2'b00;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_legal;
    logic        resp_solved;
    logic [3:0]  src0;
    logic [3:0]  src1;
    logic [39:0] data0;
    logic [39:0] data1;
    logic        we;
    logic [3:0]  dst;
    logic [39:0] data;

    int total = 0;
    int bad = 0;

    logic [39:0] rf [16] = '{default: '0};
    logic        host_wr = 1'b0;
    logic [3:0]  host_addr = '0;
    logic [39:0] host_val = '0;

    move_executor #(
        .ORD_REG(4'd0),
        .CNT_REG(4'd1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_dir     (req_dir),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_legal  (resp_legal),
        .resp_solved (resp_solved),
        .src0        (src0),
        .src1        (src1),
        .data0       (data0),
        .data1       (data1),
        .we          (we),
        .dst         (dst),
        .data        (data)
    );

    always #5 clk = ~clk;

    assign data0 = rf[src0];
    assign data1 = rf[src1];

    // Register file: DUT writes take priority; host writes only happen while idle.
    always @(posedge clk) begin
        if (we) rf[dst] <= data;
        else if (host_wr) rf[host_addr] <= host_val;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Move model on an array of tiles with row/column arithmetic.
    function automatic void model_move(input logic [17:0] b, input logic [1:0] d,
                                       output logic lg, output logic [17:0] nb);
        int t [6];
        int p;
        int tg;
        int tmp;
        for (int i = 0; i < 6; i++) t[i] = int'(b[17-3*i -: 3]);
        p = -1;
        for (int i = 0; i < 6; i++) if (p < 0 && t[i] == 0) p = i;
        lg = 1'b0;
        tg = 0;
        nb = b;
        if (p >= 0) begin
            case (d)
                2'b00: if (p / 3 == 1) begin lg = 1'b1; tg = p - 3; end
                2'b01: if (p / 3 == 0) begin lg = 1'b1; tg = p + 3; end
                2'b10: if (p % 3 != 0) begin lg = 1'b1; tg = p - 1; end
                default: if (p % 3 != 2) begin lg = 1'b1; tg = p + 1; end
            endcase
        end
        if (lg) begin
            tmp = t[p]; t[p] = t[tg]; t[tg] = tmp;
            for (int i = 0; i < 6; i++) nb[17-3*i -: 3] = 3'(t[i]);
        end
    endfunction

    function automatic logic [17:0] rand_perm();
        int t [6];
        int j;
        int tmp;
        logic [17:0] b;
        for (int i = 0; i < 6; i++) t[i] = i;
        for (int i = 5; i > 0; i--) begin
            j = int'($urandom % 32'(i + 1));
            tmp = t[i]; t[i] = t[j]; t[j] = tmp;
        end
        b = '0;
        for (int i = 0; i < 6; i++) b[17-3*i -: 3] = 3'(t[i]);
        return b;
    endfunction

    // Per-cycle checker state.
    logic        c_busy = 1'b0;
    int          c_age = 0;
    logic        c_legal = 1'b0;
    logic [17:0] c_nb = '0;
    logic [39:0] c_brd = '0;
    logic [39:0] c_cnt = '0;
    logic        e_ready, e_rv, e_rl, e_rs, e_we;
    logic [3:0]  e_dst;
    logic [39:0] e_data;

    // Compare every output on every falling edge against the transaction timeline.
    always @(negedge clk) begin
        e_ready = 1'b0; e_rv = 1'b0; e_rl = 1'b0; e_rs = 1'b0;
        e_we = 1'b0; e_dst = '0; e_data = '0;
        if (!rst_n) begin
            c_busy  = 1'b0;
            e_ready = 1'b1;
        end else if (!c_busy) begin
            e_ready = 1'b1;
        end else begin
            c_age++;
            if (c_legal) begin
                if (c_age == 3) begin
                    e_we = 1'b1; e_dst = 4'd0; e_data = {c_brd[39:18], c_nb};
                end else if (c_age == 4) begin
                    e_we = 1'b1; e_dst = 4'd1; e_data = c_cnt + 40'd1;
                end else if (c_age == 5) begin
                    e_rv = 1'b1; e_rl = 1'b1; e_rs = (c_nb == 18'h0A728);
                end
            end else if (c_age == 3) begin
                e_rv = 1'b1; e_rs = (c_nb == 18'h0A728);
            end
        end
        chk("req_ready",   64'(req_ready),   64'(e_ready));
        chk("resp_valid",  64'(resp_valid),  64'(e_rv));
        chk("resp_legal",  64'(resp_legal),  64'(e_rl));
        chk("resp_solved", 64'(resp_solved), 64'(e_rs));
        chk("we",          64'(we),          64'(e_we));
        chk("dst",         64'(dst),         64'(e_dst));
        chk("data",        64'(data),        64'(e_data));
        chk("src0",        64'(src0),        64'(4'd0));
        chk("src1",        64'(src1),        64'(4'd1));
        if (rst_n) begin
            if (c_busy && c_age == (c_legal ? 5 : 3)) begin
                c_busy = 1'b0;
            end else if (!c_busy && req_valid) begin
                c_busy = 1'b1;
                c_age  = 0;
                c_brd  = rf[0];
                c_cnt  = rf[1];
                model_move(c_brd[17:0], req_dir, c_legal, c_nb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [39:0] v);
        host_wr = 1'b1; host_addr = a; host_val = v;
        step();
        host_wr = 1'b0;
    endtask

    // Issue one request from an idle DUT and capture the response (bounded wait).
    task automatic run_move(input logic [1:0] d, output logic lg, output logic sv, output int lat);
        lg = 1'b0; sv = 1'b0; lat = -1;
        req_valid = 1'b1; req_dir = d;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; lg = resp_legal; sv = resp_solved;
                break;
            end
        end
        if (lat < 0) chk("resp_timeout", 64'(0), 64'(1));
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lg;
        logic        sv;
        int          lat;
        logic [17:0] nb;

        // Pin the model against hand-worked boards.
        model_move(18'h0A728, 2'b10, lg, nb);
        chk("pin_left_legal", 64'(lg), 64'(1)); chk("pin_left_board", 64'(nb), 64'(18'h0A705));
        model_move(18'h0A728, 2'b01, lg, nb);
        chk("pin_down_legal", 64'(lg), 64'(0)); chk("pin_down_board", 64'(nb), 64'(18'h0A728));
        model_move(18'h0A728, 2'b00, lg, nb);
        chk("pin_up_board", 64'(nb), 64'(18'h0A12B));
        model_move(18'h0A12B, 2'b01, lg, nb);
        chk("pin_back_board", 64'(nb), 64'(18'h0A728));
        model_move(18'h0A729, 2'b10, lg, nb);
        chk("pin_noblank_legal", 64'(lg), 64'(0));

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();

        // Left from solved board, upper bits preserved.
        set_reg(4'd0, {22'h2A5A5A, 18'h0A728});
        set_reg(4'd1, 40'd0);
        run_move(2'b10, lg, sv, lat);
        chk("left_lat", 64'(lat), 64'(5)); chk("left_legal", 64'(lg), 64'(1)); chk("left_solved", 64'(sv), 64'(0));
        chk("left_board", 64'(rf[0]), 64'({22'h2A5A5A, 18'h0A705}));
        chk("left_cnt", 64'(rf[1]), 64'(1));

        // Down from bottom row is illegal.
        set_reg(4'd0, 40'h0A728);
        run_move(2'b01, lg, sv, lat);
        chk("down_lat", 64'(lat), 64'(3)); chk("down_legal", 64'(lg), 64'(0)); chk("down_solved", 64'(sv), 64'(1));
        chk("down_board", 64'(rf[0]), 64'(40'h0A728)); chk("down_cnt", 64'(rf[1]), 64'(1));

        // Up then back down returns to solved.
        run_move(2'b00, lg, sv, lat);
        chk("up_board", 64'(rf[0]), 64'(40'h0A12B)); chk("up_cnt", 64'(rf[1]), 64'(2));
        run_move(2'b01, lg, sv, lat);
        chk("back_board", 64'(rf[0]), 64'(40'h0A728)); chk("back_solved", 64'(sv), 64'(1)); chk("back_lat", 64'(lat), 64'(5));

        // Counter wraps to zero.
        set_reg(4'd1, 40'hFF_FFFF_FFFF);
        run_move(2'b10, lg, sv, lat);
        chk("wrap_cnt", 64'(rf[1]), 64'(0));

        // No blank on the board.
        set_reg(4'd0, 40'h0A729);
        set_reg(4'd1, 40'd7);
        run_move(2'b00, lg, sv, lat);
        chk("noblank_lat", 64'(lat), 64'(3)); chk("noblank_legal", 64'(lg), 64'(0));
        chk("noblank_board", 64'(rf[0]), 64'(40'h0A729)); chk("noblank_cnt", 64'(rf[1]), 64'(7));

        // Reset during the board write abandons the move.
        set_reg(4'd0, 40'h0A728);
        set_reg(4'd1, 40'd5);
        req_valid = 1'b1; req_dir = 2'b10;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("rst_pre_we", 64'(we), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_we", 64'(we), 64'(0)); chk("rst_dst", 64'(dst), 64'(0)); chk("rst_data", 64'(data), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1)); chk("rst_resp", 64'(resp_valid), 64'(0));
        step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("rst_board", 64'(rf[0]), 64'(40'h0A728)); chk("rst_cnt", 64'(rf[1]), 64'(5));

        // Randomized traffic; the falling-edge checker judges every cycle.
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            req_valid = 1'b0;
            if (req_ready) begin
                r = $urandom % 6;
                if (r == 0) begin
                    host_wr = 1'b1; host_addr = 4'd0;
                    host_val = {22'($urandom), (($urandom % 4) == 0) ? 18'($urandom) : rand_perm()};
                end else if (r == 1) begin
                    host_wr = 1'b1; host_addr = 4'd1;
                    host_val = (($urandom % 3) == 0) ? '1 : {8'($urandom), $urandom};
                end else begin
                    req_valid = 1'b1; req_dir = 2'($urandom);
                end
            end else begin
                req_valid = 1'($urandom); req_dir = 2'($urandom);
            end
            step();
            host_wr = 1'b0;
        end
        req_valid = 1'b0;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
